// File: rtl/lis3dh_seq.sv
// lis3dh_seq: register-level sequencer in front of the LIS3DH SPI master.
// After enable it reads WHO_AM_I and checks it, writes CTRL_REG1 and CTRL_REG4,
// then polls OUT_X/Y/Z once per poll period and publishes a signed 16-bit triple.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   enable              level; 0 returns to IDLE at the next transfer boundary
//   spi_rd / spi_wr     one-cycle request pulses to the SPI master
//   spi_addr            register address, held from request until completion
//   spi_data_tx         write data, held like spi_addr, 0 for reads
//   spi_data_rx         read data {reg[addr], reg[addr+1]}
//   spi_cs              SPI master chip select, low while a transfer runs
//   x_out/y_out/z_out   published samples, {H,L} byte order
//   sample_valid        one-cycle pulse coincident with new x/y/z values
//   busy                high in every state except IDLE and ERROR
//   error, err_code     sticky error flag; 01 = WHO_AM_I mismatch, 10 = timeout
module lis3dh_seq #(
  parameter int         POLL_CYCLES    = 100000,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] CTRL1_VAL      = 8'h57,
  parameter logic [7:0] CTRL4_VAL      = 8'h88,
  parameter logic [7:0] WHOAMI_VAL     = 8'h33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        spi_rd,
  output logic        spi_wr,
  output logic [5:0]  spi_addr,
  output logic [7:0]  spi_data_tx,
  input  logic [15:0] spi_data_rx,
  input  logic        spi_cs,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(POLL_CYCLES + 1);
  // The request cycle itself counts toward the transfer budget, so the
  // wait-phase counter starts one short of TIMEOUT_CYCLES.
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  // sample_valid is registered, so POLL_WAIT starts on the pulse cycle and
  // must last POLL_CYCLES cycles: load POLL_CYCLES-1 and leave at zero.
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);

  localparam logic [5:0] ADDR_WHOAMI = 6'h0F;
  localparam logic [5:0] ADDR_CTRL1  = 6'h20;
  localparam logic [5:0] ADDR_CTRL4  = 6'h23;
  localparam logic [5:0] ADDR_OUT_X  = 6'h28;

  typedef enum logic [3:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_CFG1_REQ, S_CFG1_WAIT, S_CFG4_REQ,
    S_CFG4_WAIT, S_POLL_WAIT, S_RD_REQ, S_RD_WAIT, S_PUBLISH, S_ERROR
  } state_t;

  state_t          state, state_n;
  logic            started;
  logic [TW-1:0]   tmo_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [1:0]      axis;
  logic [15:0]     x_sh, y_sh, z_sh;
  logic            is_req, is_wait, done, tmo_exp, id_bad;

  // enable is only honoured where the next step would issue a new request.
  function automatic state_t go_req(state_t s, logic en);
    return en ? s : S_IDLE;
  endfunction

  assign is_req  = (state == S_ID_REQ) || (state == S_CFG1_REQ) ||
                   (state == S_CFG4_REQ) || (state == S_RD_REQ);
  assign is_wait = (state == S_ID_WAIT) || (state == S_CFG1_WAIT) ||
                   (state == S_CFG4_WAIT) || (state == S_RD_WAIT);
  // A cs-high glitch before cs was ever seen low does not count as completion.
  assign done    = is_wait && started && spi_cs;
  assign tmo_exp = is_wait && !done && (tmo_cnt <= TW'(1));
  assign id_bad  = (state == S_ID_WAIT) && done && (spi_data_rx[15:8] != WHOAMI_VAL);
  assign busy    = (state != S_IDLE) && (state != S_ERROR);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (enable) state_n = S_ID_REQ;
      S_ID_REQ:    state_n = S_ID_WAIT;
      S_ID_WAIT:   if (done) state_n = id_bad ? S_ERROR : go_req(S_CFG1_REQ, enable);
      S_CFG1_REQ:  state_n = S_CFG1_WAIT;
      S_CFG1_WAIT: if (done) state_n = go_req(S_CFG4_REQ, enable);
      S_CFG4_REQ:  state_n = S_CFG4_WAIT;
      S_CFG4_WAIT: if (done) state_n = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (!enable)            state_n = S_IDLE;
        else if (poll_cnt == '0) state_n = S_RD_REQ;
      end
      S_RD_REQ:    state_n = S_RD_WAIT;
      S_RD_WAIT:   if (done) state_n = (axis == 2'd2) ? S_PUBLISH : go_req(S_RD_REQ, enable);
      S_PUBLISH:   state_n = S_POLL_WAIT;
      S_ERROR:     state_n = S_ERROR;
      default:     state_n = S_IDLE;
    endcase
    if (tmo_exp) state_n = S_ERROR;
  end

  // Address/data are decoded from the state so they stay stable for the
  // whole request + wait span without extra holding registers.
  always_comb begin
    spi_addr    = '0;
    spi_data_tx = '0;
    case (state)
      S_ID_REQ, S_ID_WAIT:     spi_addr = ADDR_WHOAMI;
      S_CFG1_REQ, S_CFG1_WAIT: begin spi_addr = ADDR_CTRL1; spi_data_tx = CTRL1_VAL; end
      S_CFG4_REQ, S_CFG4_WAIT: begin spi_addr = ADDR_CTRL4; spi_data_tx = CTRL4_VAL; end
      S_RD_REQ, S_RD_WAIT:     spi_addr = ADDR_OUT_X + {3'b000, axis, 1'b0};
      default: ;
    endcase
    spi_rd = (state == S_ID_REQ) || (state == S_RD_REQ);
    spi_wr = (state == S_CFG1_REQ) || (state == S_CFG4_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      started      <= 1'b0;
      tmo_cnt      <= '0;
      poll_cnt     <= '0;
      axis         <= '0;
      x_sh         <= '0;
      y_sh         <= '0;
      z_sh         <= '0;
      x_out        <= '0;
      y_out        <= '0;
      z_out        <= '0;
      sample_valid <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      sample_valid <= 1'b0;

      if (is_req) begin
        started <= 1'b0;
        tmo_cnt <= TMO_LOAD;
      end else if (is_wait) begin
        if (!spi_cs) started <= 1'b1;
        tmo_cnt <= tmo_cnt - TW'(1);
      end

      if (state != S_POLL_WAIT && state_n == S_POLL_WAIT) poll_cnt <= POLL_LOAD;
      else if (state == S_POLL_WAIT)                      poll_cnt <= poll_cnt - PW'(1);

      if (state == S_POLL_WAIT) axis <= 2'd0;

      // Sensor returns {L,H}; store as {H,L}.
      if (state == S_RD_WAIT && done) begin
        case (axis)
          2'd0:    x_sh <= {spi_data_rx[7:0], spi_data_rx[15:8]};
          2'd1:    y_sh <= {spi_data_rx[7:0], spi_data_rx[15:8]};
          default: z_sh <= {spi_data_rx[7:0], spi_data_rx[15:8]};
        endcase
        axis <= axis + 2'd1;
      end

      if (state == S_PUBLISH) begin
        x_out        <= x_sh;
        y_out        <= y_sh;
        z_out        <= z_sh;
        sample_valid <= 1'b1;
      end

      if (id_bad) begin
        error    <= 1'b1;
        err_code <= 2'b01;
      end else if (tmo_exp) begin
        error    <= 1'b1;
        err_code <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_lis3dh_seq.sv
// Bench for lis3dh_seq: a behavioural SPI slave with a register map and random
// latencies answers requests; transactions and sample pulses are logged and
// compared with the register-level sequence the sequencer is expected to run.
module tb_lis3dh_seq;

  localparam int POLL = 10;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        spi_rd, spi_wr;
  logic [5:0]  spi_addr;
  logic [7:0]  spi_data_tx;
  logic [15:0] spi_data_rx = '0;
  logic        spi_cs = 1'b1;
  logic [15:0] x_out, y_out, z_out;
  logic        sample_valid, busy, error;
  logic [1:0]  err_code;

  lis3dh_seq #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_data_tx(spi_data_tx),
    .spi_data_rx(spi_data_rx), .spi_cs(spi_cs),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .sample_valid(sample_valid), .busy(busy), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [5:0] addr; logic [7:0] data; int cyc; } xact_t;
  typedef struct { int cyc; logic [15:0] x, y, z; } pulse_t;

  xact_t       xlog[$];
  pulse_t      pulses[$];
  xact_t       cur;
  logic [7:0]  regs [64];
  logic [15:0] rx_last [64];
  int          cyc = 0, ph = 0, cnt = 0, n_done = 0, both_cnt = 0, bad_chg = 0;
  int          n_chk = 0, n_fail = 0;
  logic        hang = 1'b0;
  logic [47:0] prev_xyz = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_log(int n, int budget, string tag);
    int b = 0;
    while (xlog.size() < n && b < budget) begin tick(); b++; end
    chk(tag, 32'(xlog.size() >= n), 1);
  endtask

  task automatic wait_pulses(int n, int budget, string tag);
    int b = 0;
    while (pulses.size() < n && b < budget) begin tick(); b++; end
    chk(tag, 32'(pulses.size() >= n), 1);
  endtask

  task automatic chk_xact(string tag, int i, logic wr, logic [5:0] addr, logic [7:0] data);
    if (i >= xlog.size()) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      chk({tag, "_type"}, 32'(xlog[i].wr), 32'(wr));
      chk({tag, "_addr"}, 32'(xlog[i].addr), 32'(addr));
      if (wr) chk({tag, "_data"}, 32'(xlog[i].data), 32'(data));
    end
  endtask

  function automatic int count_wr(int from);
    int n = 0;
    for (int i = from; i < xlog.size(); i++) if (xlog[i].wr) n++;
    return n;
  endfunction

  // SPI slave model: random start delay, random cs-low length, data valid with cs rise.
  always @(negedge clk) begin
    logic [5:0] a, a1;
    cyc++;
    if (spi_rd && spi_wr) both_cnt++;
    if (reset) begin
      ph = 0; spi_cs = 1'b1;
    end else if (spi_rd || spi_wr) begin
      cur.wr = spi_wr; cur.addr = spi_addr; cur.data = spi_data_tx; cur.cyc = cyc;
      xlog.push_back(cur);
      if (!spi_wr) chk("rd_data_tx_zero", 32'(spi_data_tx), 0);
      ph  = hang ? 3 : 1;
      cnt = $urandom_range(0, 3);
    end else begin
      case (ph)
        1: if (cnt == 0) begin spi_cs = 1'b0; ph = 2; cnt = $urandom_range(1, 4); end
           else cnt--;
        2: if (cnt == 0) begin
             chk("addr_hold", 32'(spi_addr), 32'(cur.addr));
             a = cur.addr; a1 = a + 6'd1;
             spi_data_rx = {regs[a], regs[a1]};
             if (cur.wr) regs[a] = cur.data;
             else rx_last[a] = spi_data_rx;
             if (!cur.wr && a == 6'h2C)
               for (int k = 8'h28; k <= 8'h2D; k++) regs[k] = 8'($urandom);
             spi_cs = 1'b1; ph = 0; n_done++;
           end else cnt--;
        default: ;
      endcase
    end
    // Sample consumer: samples are the last returned OUT bytes, byte-swapped.
    if (sample_valid) begin
      pulse_t p;
      p.cyc = cyc; p.x = x_out; p.y = y_out; p.z = z_out;
      pulses.push_back(p);
      chk("pulse_x", 32'(x_out), 32'({rx_last[6'h28][7:0], rx_last[6'h28][15:8]}));
      chk("pulse_y", 32'(y_out), 32'({rx_last[6'h2A][7:0], rx_last[6'h2A][15:8]}));
      chk("pulse_z", 32'(z_out), 32'({rx_last[6'h2C][7:0], rx_last[6'h2C][15:8]}));
    end else if (!reset && {x_out, y_out, z_out} != prev_xyz) begin
      bad_chg++;
    end
    prev_xyz = {x_out, y_out, z_out};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, np;
    for (int i = 0; i < 64; i++) begin regs[i] = 8'h00; rx_last[i] = 16'h0; end
    regs[6'h0F] = 8'h33;
    regs[6'h28] = 8'h34; regs[6'h29] = 8'h12;
    regs[6'h2A] = 8'h78; regs[6'h2B] = 8'h56;
    regs[6'h2C] = 8'hBC; regs[6'h2D] = 8'h9A;
    repeat (3) tick();

    // Reset state
    chk("rst_rd", 32'(spi_rd), 0);
    chk("rst_wr", 32'(spi_wr), 0);
    chk("rst_addr", 32'(spi_addr), 0);
    chk("rst_xyz", 32'(|{x_out, y_out, z_out, spi_data_tx}), 0);
    chk("rst_flags", 32'({sample_valid, busy, error, err_code}), 0);

    // Normal bring-up and three triples
    reset = 1'b0; enable = 1'b1;
    wait_pulses(3, 3000, "A_three_pulses");
    chk_xact("A_id",   0, 1'b0, 6'h0F, 8'h00);
    chk_xact("A_cfg1", 1, 1'b1, 6'h20, 8'h57);
    chk_xact("A_cfg4", 2, 1'b1, 6'h23, 8'h88);
    for (int t = 0; t < 3; t++) begin
      chk_xact("A_rdx", 3 + 3*t, 1'b0, 6'h28, 8'h00);
      chk_xact("A_rdy", 4 + 3*t, 1'b0, 6'h2A, 8'h00);
      chk_xact("A_rdz", 5 + 3*t, 1'b0, 6'h2C, 8'h00);
    end
    if (pulses.size() >= 3 && xlog.size() >= 12) begin
      chk("A_first_x", 32'(pulses[0].x), 32'h1234);
      chk("A_first_y", 32'(pulses[0].y), 32'h5678);
      chk("A_first_z", 32'(pulses[0].z), 32'h9ABC);
      chk("A_poll_gap0", 32'(xlog[6].cyc - pulses[0].cyc), POLL);
      chk("A_poll_gap1", 32'(xlog[9].cyc - pulses[1].cyc), POLL);
      chk("A_pulse_after_z", 32'(pulses[0].cyc > xlog[5].cyc && pulses[0].cyc < xlog[6].cyc), 1);
    end
    chk("A_busy", 32'(busy), 1);
    chk("A_error", 32'(error), 0);

    // enable drops during the y read
    base = xlog.size();
    for (int b = 0; b < 500; b++) begin
      if (xlog.size() > base && xlog[$].addr == 6'h2A) break;
      tick();
    end
    chk("B_saw_y_read", 32'(xlog.size() > base && xlog[$].addr == 6'h2A), 1);
    enable = 1'b0;
    np = pulses.size(); base = xlog.size();
    for (int b = 0; b < 200 && busy; b++) tick();
    repeat (3) tick();
    chk("B_idle", 32'(busy), 0);
    chk("B_no_z_read", 32'(xlog.size() - base), 0);
    chk("B_no_pulse", 32'(pulses.size() - np), 0);
    chk("B_y_completed", 32'(n_done), 32'(xlog.size()));
    enable = 1'b1;
    wait_log(base + 2, 300, "B_restart");
    chk_xact("B_restart_id", base, 1'b0, 6'h0F, 8'h00);
    chk_xact("B_restart_cfg1", base + 1, 1'b1, 6'h20, 8'h57);

    // Reset during CFG1_WAIT (the CTRL1 write was just requested)
    reset = 1'b1;
    tick();
    chk("R_rdwr", 32'({spi_rd, spi_wr}), 0);
    chk("R_addr_data", 32'({spi_addr, spi_data_tx}), 0);
    chk("R_xyz", 32'(|{x_out, y_out, z_out}), 0);
    chk("R_flags", 32'({sample_valid, busy, error, err_code}), 0);
    tick();
    base = xlog.size();
    reset = 1'b0;
    wait_log(base + 1, 50, "R_restart");
    chk_xact("R_restart_id", base, 1'b0, 6'h0F, 8'h00);

    // WHO_AM_I mismatch
    reset = 1'b1; regs[6'h0F] = 8'h32;
    repeat (2) tick();
    base = xlog.size();
    reset = 1'b0;
    for (int b = 0; b < 500 && !error; b++) tick();
    repeat (20) tick();
    chk("C_error", 32'(error), 1);
    chk("C_err_code", 32'(err_code), 1);
    chk("C_busy", 32'(busy), 0);
    chk("C_no_writes", 32'(count_wr(base)), 0);
    chk("C_one_read", 32'(xlog.size() - base), 1);

    // Timeout: slave never lowers cs
    reset = 1'b1; regs[6'h0F] = 8'h33; hang = 1'b1;
    repeat (2) tick();
    base = xlog.size();
    reset = 1'b0;
    wait_log(base + 1, 50, "D_req_seen");
    repeat (13) tick();
    chk("D_no_err_early", 32'(error), 0);
    repeat (3) tick();
    chk("D_error", 32'(error), 1);
    chk("D_err_code", 32'(err_code), 2);
    chk("D_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      enable = ~enable;
      repeat (5) tick();
      chk("D_sticky_err", 32'({error, err_code}), 32'({1'b1, 2'b10}));
    end
    chk("D_no_new_req", 32'(xlog.size() - base), 1);
    reset = 1'b1; hang = 1'b0; enable = 1'b0;
    tick();
    chk("D_reset_clears", 32'({error, err_code, busy}), 0);
    tick();
    reset = 1'b0;
    tick();

    chk("never_rd_and_wr", 32'(both_cnt), 0);
    chk("xyz_only_on_pulse", 32'(bad_chg), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lis3dh_seq.md
Name: lis3dh_seq

Overview:
- Sequencer that drives the LIS3DH SPI master's rd/wr/addr/data_tx handshake.
- After enable it reads WHO_AM_I and checks it, then writes the two configuration registers.
- It then polls OUT_X/Y/Z at a fixed period and publishes one signed 16-bit sample triple per poll.
- Sits between the SPI master and the downstream sample consumer; it is the only requester of the SPI master.

Parameters:
- POLL_CYCLES, 100000, clk cycles from the end of one XYZ triple to the start of the next triple's first read (>=1).
- TIMEOUT_CYCLES, 4096, maximum clk cycles per transfer from request pulse to completion.
- CTRL1_VAL, 8'h57, value written to CTRL_REG1 (addr 6'h20).
- CTRL4_VAL, 8'h88, value written to CTRL_REG4 (addr 6'h23).
- WHOAMI_VAL, 8'h33, expected WHO_AM_I (addr 6'h0F) contents.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run the sequence, 0 = return to IDLE at the next transfer boundary.
- spi_rd  out  1  one-cycle read request pulse to the SPI master.
- spi_wr  out  1  one-cycle write request pulse to the SPI master.
- spi_addr  out  6  register address; held stable from the request pulse until completion.
- spi_data_tx  out  8  write data; held like spi_addr, 8'h00 for reads.
- spi_data_rx  in  16  read data. [15:8] = reg[addr], [7:0] = reg[addr+1].
- spi_cs  in  1  SPI master chip select; low while a transfer is in progress.
- x_out, y_out, z_out  out  16 each  signed samples, {H,L} byte order.
- sample_valid  out  1  one-cycle pulse when x/y/z are updated together.
- busy  out  1  high in every state except IDLE and ERROR.
- error  out  1  sticky; cleared only by reset.
- err_code  out  2  2'b01 = WHO_AM_I mismatch, 2'b10 = timeout; 2'b00 otherwise.

Behaviour:
- Reset: all outputs 0; state = IDLE; counters and started flag cleared. Reset mid-transfer aborts immediately; the SPI master is not informed.
- States: IDLE, ID_REQ, ID_WAIT, CFG1_REQ, CFG1_WAIT, CFG4_REQ, CFG4_WAIT, POLL_WAIT, RD_REQ, RD_WAIT, PUBLISH, ERROR.
- IDLE: when enable=1, go to ID_REQ.
- Every *_REQ state lasts exactly one cycle:
  - Asserts spi_rd or spi_wr for that cycle and drives spi_addr/spi_data_tx.
  - Clears the started flag and loads the timeout counter.
  - spi_rd and spi_wr are never high together.
- Every *_WAIT state:
  - Sets started when spi_cs==0 is sampled.
  - Completion = started && spi_cs==1; spi_data_rx is captured on that same cycle.
  - The timeout counter decrements each cycle. Reaching 0 before completion -> ERROR, err_code=2'b10.
- ID_WAIT completion:
  - If spi_data_rx[15:8]==WHOAMI_VAL, go to CFG1_REQ.
  - Otherwise go to ERROR with err_code=2'b01.
- Configuration writes: CFG1_REQ writes (6'h20, CTRL1_VAL), then CFG4_REQ writes (6'h23, CTRL4_VAL). CFG4_WAIT completion -> POLL_WAIT.
- POLL_WAIT: counts POLL_CYCLES cycles, then goes to RD_REQ with axis index 0.
- RD_REQ reads addresses 6'h28, 6'h2A, 6'h2C for axis 0, 1, 2. Each RD_WAIT completion stores {rx[7:0], rx[15:8]} into a shadow register for that axis.
- After axis 2 completes, PUBLISH (one cycle):
  - Copies all three shadow registers to x/y/z_out simultaneously.
  - Pulses sample_valid.
  - Goes to POLL_WAIT.
- x/y/z_out never change except in PUBLISH; they are never partially updated.
- enable dropping:
  - Checked only on entry to a *_REQ state and in POLL_WAIT; the controller goes to IDLE from there. An in-flight transfer always completes.
  - Re-enable restarts from ID_REQ; configuration is always rewritten.
- ERROR: spi_rd/spi_wr stay 0 and the state stays in ERROR until reset, regardless of enable.
- If spi_cs never goes low after a request, the transfer times out as above.
- A glitch of spi_cs high before started is set is ignored.

Test Plan:
- Reset, enable=1, SPI model returns WHO_AM_I 8'h33 → exactly one rd to 6'h0F, then wr (6'h20,8'h57), then wr (6'h23,8'h88), busy=1, error=0.
- Model returns WHO_AM_I 8'h32 → error=1, err_code=2'b01, no spi_wr ever asserted, busy=0.
- Model returns rx 16'h3412/16'h7856/16'hBC9A for 0x28/0x2A/0x2C → x=16'h1234, y=16'h5678, z=16'h9ABC with one sample_valid pulse. Next triple's rd occurs POLL_CYCLES cycles after the pulse (use POLL_CYCLES=10).
- Model holds spi_cs=1 after a read request (TIMEOUT_CYCLES=16) → ERROR after 16 cycles, err_code=2'b10, sticky through enable toggles until reset.
- enable drops during the y-axis RD_WAIT → the y transfer completes, no z read is issued, no sample_valid pulse, IDLE. Re-enable → the sequence restarts with a read of 6'h0F.
- reset asserted mid CFG1_WAIT → next cycle all outputs 0, state IDLE. With enable=1 after reset the sequence starts at WHO_AM_I.
